// File: rtl/bitmask_gen_pkg.sv
// ---------------------------------------------------------------------------
// bitmask_gen_pkg
//
// Purpose : Shared definitions for the count-to-mask generator. The default
//           word and count widths are also used by the popcount unit, so a
//           generated mask can be fed straight back into it for checking.
//
// Contents:
//   DEFAULT_WIDTH - default output word width (bits)
//   DEFAULT_CW    - default count width; 2**DEFAULT_CW must exceed DEFAULT_WIDTH
//   state_t       - FSM state encoding (IDLE / FILL / DONE)
// ---------------------------------------------------------------------------
package bitmask_gen_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CW    = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : bitmask_gen_pkg

// File: rtl/bitmask_gen_shift.sv
// ---------------------------------------------------------------------------
// bitmask_shift
//
// Purpose : Mask register for the count-to-mask generator. It can be cleared
//           or shifted by one position with a 1 shifted in. The fill
//           direction is chosen at build time.
//
// Build option:
//   BITMASK_GEN_MSB_FILL_EN - when defined, each shift moves the word right
//                             and inserts the 1 at bit WIDTH-1, so the set
//                             bits grow down from the MSB. When undefined,
//                             the word moves left and the 1 enters at bit 0.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset, clears the mask
//   clear  in   clear the mask on the next edge (has priority over shift)
//   shift  in   shift one 1 into the mask on the next edge
//   mask   out  registered mask word [WIDTH-1:0]
// ---------------------------------------------------------------------------
module bitmask_shift #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift,
   output logic [WIDTH-1:0] mask
);

   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;

   // Next mask value. Clear wins over shift so that a new request always
   // starts from an empty word.
   always_comb begin
      mask_d = mask_q;
      if (clear) begin
         mask_d = '0;
      end else if (shift) begin
`ifdef BITMASK_GEN_MSB_FILL_EN
         mask_d = {1'b1, mask_q[WIDTH-1:1]};
`else
         mask_d = {mask_q[WIDTH-2:0], 1'b1};
`endif
      end
   end

   // Mask register
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

   assign mask = mask_q;

endmodule : bitmask_shift

// File: rtl/bitmask_gen.sv
// ---------------------------------------------------------------------------
// bitmask_gen
//
// Purpose : Inverse of popcount. Takes a bit count and builds, one bit per
//           clock, a word with exactly that many contiguous bits set.
//           Requests use a start / busy / done handshake. Counts above
//           WIDTH are clamped to WIDTH and flagged on sat.
//
// Build option:
//   BITMASK_GEN_MSB_FILL_EN - fill from the MSB down instead of from bit 0
//                             up (see bitmask_shift). Timing and handshake
//                             are the same in both builds.
//
// Parameters:
//   WIDTH  output word width
//   CW     count width, 2**CW > WIDTH
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   request; only taken in IDLE or DONE
//   cnt    in   number of bits to set, sampled with an accepted start
//   mask   out  generated word (registered)
//   busy   out  high while the word is being filled
//   done   out  high while a finished result is held
//   sat    out  the accepted cnt was larger than WIDTH
// ---------------------------------------------------------------------------
module bitmask_gen
   import bitmask_gen_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = DEFAULT_CW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CW-1:0]    cnt,
   output logic [WIDTH-1:0] mask,
   output logic             busy,
   output logic             done,
   output logic             sat
);

   localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);
   localparam logic [CW-1:0] ONE_CNT   = CW'(1);

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] rem_q;
   logic [CW-1:0] rem_d;
   logic          sat_q;
   logic          sat_d;

   logic          accept;
   logic          over;
   logic [CW-1:0] clamped;
   logic          clear_en;
   logic          shift_en;

   // Next-state logic. A request is taken only from IDLE or DONE, so a
   // start during FILL is simply dropped. The remaining counter is loaded
   // with the clamped count and FILL is left on the edge that consumes the
   // last bit, which keeps rem from ever wrapping below zero.
   always_comb begin
      over     = (cnt > WIDTH_CNT);
      clamped  = over ? WIDTH_CNT : cnt;
      accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

      state_d  = state_q;
      rem_d    = rem_q;
      sat_d    = sat_q;
      clear_en = 1'b0;
      shift_en = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               clear_en = 1'b1;
               rem_d    = clamped;
               sat_d    = over;
               state_d  = (clamped == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            shift_en = 1'b1;
            rem_d    = rem_q - ONE_CNT;
            if (rem_q == ONE_CNT) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, remaining-count and saturation registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sat_q   <= sat_d;
      end
   end

   bitmask_shift #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk   (clk),
      .reset (reset),
      .clear (clear_en),
      .shift (shift_en),
      .mask  (mask)
   );

   assign busy = (state_q == ST_FILL);
   assign done = (state_q == ST_DONE);
   assign sat  = sat_q;

endmodule : bitmask_gen

// File: tb/tb_bitmask_gen.sv
// ---------------------------------------------------------------------------
// tb_bitmask_gen
//
// Directed bench for bitmask_gen with hand-computed expected masks. Builds
// with or without BITMASK_GEN_MSB_FILL_EN; the expected mask follows the
// same macro.
// ---------------------------------------------------------------------------
module tb_bitmask_gen;

   localparam int WIDTH = 32;
   localparam int CW    = 6;

   logic             clk;
   logic             reset;
   logic             start;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mask;
   logic             busy;
   logic             done;
   logic             sat;

   int checkCount;
   int passCount;
   int edges;
   int busyCnt;

   bitmask_gen #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .cnt   (cnt),
      .mask  (mask),
      .busy  (busy),
      .done  (done),
      .sat   (sat)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected word for n set bits in the current fill direction
   function automatic logic [31:0] expMask(input int n);
      logic [63:0] ones;
      ones = 64'h0000_0000_FFFF_FFFF;
`ifdef BITMASK_GEN_MSB_FILL_EN
      return 32'(~(ones >> n));
`else
      return 32'(~(ones << n));
`endif
   endfunction

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a one-cycle start with the given count (consumes the accept edge)
   task automatic applyStimulus(input int n);
      start = 1'b1;
      cnt   = CW'(n);
      tick();
      start = 1'b0;
   endtask

   // Wait for done with a cycle bound, reporting edges waited and busy cycles
   task automatic waitDone(output int nEdges, output int nBusy);
      nEdges = 0;
      nBusy  = 0;
      while (done !== 1'b1 && nEdges < 200) begin
         if (busy === 1'b1) nBusy++;
         tick();
         nEdges++;
      end
      if (done !== 1'b1) checkOutput("done_timeout", 64'(done), 64'd1);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      start      = 1'b0;
      cnt        = '0;

      // Power-up reset
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rst_mask", 64'(mask), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_sat",  64'(sat),  64'd0);

      // Reset in the middle of a fill discards the partial word
      applyStimulus(20);
      checkOutput("f20_busy", 64'(busy), 64'd1);
      checkOutput("f20_mask0", 64'(mask), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("f20_mask5", 64'(mask), 64'(expMask(5)));
      reset = 1'b1;
      tick();
      checkOutput("midrst_mask", 64'(mask), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_done", 64'(done), 64'd0);
      checkOutput("idle_mask", 64'(mask), 64'd0);

      // Full-width count
      applyStimulus(32);
      waitDone(edges, busyCnt);
      checkOutput("c32_edges", 64'(edges), 64'd32);
      checkOutput("c32_busycyc", 64'(busyCnt), 64'd32);
      checkOutput("c32_mask", 64'(mask), 64'hFFFF_FFFF);
      checkOutput("c32_sat", 64'(sat), 64'd0);
      checkOutput("c32_busy", 64'(busy), 64'd0);
      checkOutput("c32_popcnt", 64'($countones(mask)), 64'd32);

      // Zero count finishes right at the accept edge
      applyStimulus(0);
      checkOutput("c0_done", 64'(done), 64'd1);
      checkOutput("c0_busy", 64'(busy), 64'd0);
      checkOutput("c0_mask", 64'(mask), 64'd0);
      checkOutput("c0_sat",  64'(sat),  64'd0);

      // Over-range count saturates, next accept clears sat
      applyStimulus(40);
      checkOutput("c40_sat_early", 64'(sat), 64'd1);
      waitDone(edges, busyCnt);
      checkOutput("c40_edges", 64'(edges), 64'd32);
      checkOutput("c40_mask", 64'(mask), 64'hFFFF_FFFF);
      checkOutput("c40_sat", 64'(sat), 64'd1);
      applyStimulus(1);
      checkOutput("c1_sat", 64'(sat), 64'd0);
      waitDone(edges, busyCnt);
      checkOutput("c1_edges", 64'(edges), 64'd1);
      checkOutput("c1_mask", 64'(mask), 64'(expMask(1)));

      // Start during FILL is ignored, start in DONE is taken
      applyStimulus(3);
      applyStimulus(9);
      waitDone(edges, busyCnt);
      checkOutput("c3_edges", 64'(edges), 64'd2);
      checkOutput("c3_mask", 64'(mask), 64'(expMask(3)));
      applyStimulus(9);
      waitDone(edges, busyCnt);
      checkOutput("c9_edges", 64'(edges), 64'd9);
      checkOutput("c9_mask", 64'(mask), 64'(expMask(9)));

      // Back-to-back sweep with start held high
      start = 1'b1;
      cnt   = '0;
      tick();
      for (int n = 0; n <= 32; n++) begin
         waitDone(edges, busyCnt);
         checkOutput($sformatf("sweep%0d_edges", n), 64'(edges), 64'(n));
         checkOutput($sformatf("sweep%0d_mask", n), 64'(mask), 64'(expMask(n)));
         if (n < 32) begin
            cnt = CW'(n + 1);
            tick();
            checkOutput($sformatf("sweep%0d_donepulse", n), 64'(done), 64'd0);
         end
      end
      start = 1'b0;
      tick();
      checkOutput("sweep_hold_done", 64'(done), 64'd1);
      checkOutput("sweep_hold_mask", 64'(mask), 64'hFFFF_FFFF);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule : tb_bitmask_gen

// File: doc/bitmask_gen.md
Name: bitmask_gen

Overview:
- Inverse of the team's combinational popcount: takes a bit count and serially builds a word with exactly that many bits set, one bit per cycle.
- Used by the P4 datapath test infrastructure and by count-to-mask instructions.
- Multi-cycle FSM with a start/busy/done handshake; results can be fed back into the popcount unit for self-checking.

Parameters:
- WIDTH, 32, output word width.
- CW, 6, count width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when FSM is IDLE or DONE.
- cnt  input  CW  number of bits to set; sampled with an accepted start.
- mask  output  WIDTH  generated word; registered.
- busy  output  1  high while in FILL.
- done  output  1  high while in DONE; cleared by the next accepted start or by reset.
- sat  output  1  set when the accepted cnt was greater than WIDTH; held until the next accept or reset.

Behaviour:
- Reset is synchronous and active-high on clk: state=IDLE, mask=0, busy=0, done=0, sat=0, internal remaining counter rem=0.
- FSM states: IDLE, FILL, DONE. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- Accept condition: start=1 while in IDLE or DONE. On accept:
  - mask<=0, done<=0.
  - rem<=min(cnt,WIDTH).
  - sat<=(cnt>WIDTH).
  - If the clamped count is 0, go to DONE; otherwise go to FILL.
- FILL, each cycle:
  - mask<={mask[WIDTH-2:0],1'b1}.
  - rem<=rem-1.
  - When rem==1, go to DONE in the same edge as the final shift.
- DONE: mask holds. done=1. Stays until the next accept.
- Latency: for clamped count n>0, the start is accepted at edge 0, shifts occur at edges 1..n, and done is visible after edge n+1 is not required. done is visible right after edge n (n+1 cycles including the accept cycle). For n=0, done is visible after edge 0 with mask=0.
- start during FILL is ignored; no queuing, and cnt is not resampled.
- start held high continuously: in DONE it re-accepts every time DONE is reached, so done pulses for one cycle per result.
- Arithmetic: rem is CW bits wide and never underflows, because FILL is left at rem==1. The clamp comparison is unsigned.
- Invariant: in DONE, popcount(mask)==min(cnt,WIDTH), and the set bits are contiguous from bit 0.
- reset asserted mid-FILL: next edge returns to IDLE with mask=0; any partial result is discarded.

Optional Feature:
- Macro: BITMASK_GEN_MSB_FILL_EN.
- Defined: each FILL cycle shifts right and inserts 1 at bit WIDTH-1, so the set bits are contiguous from the MSB down. Example: cnt=4 gives 32'hF000_0000.
- Undefined (default): LSB fill as above. Example: cnt=4 gives 32'h0000_000F.
- Latency, handshake and sat behaviour are identical in both builds.

Decomposition:
- Shared package holds:
  - FSM state encoding constants ST_IDLE=2'd0, ST_FILL=2'd1, ST_DONE=2'd2.
  - Default WIDTH/CW constants, shared with the popcount unit.
- One natural sub-module, bitmask_shift: holds the mask register with clear/shift-in controls and the MSB/LSB fill direction.
- The FSM and the rem counter stay in the top module.

Test Plan:
- Reset: assert reset 2 cycles mid-FILL (cnt=20, after 5 shifts) -> next cycle mask=0, busy=0, done=0, state IDLE.
- cnt=32, start 1 cycle -> busy high 32 cycles; done after the 32nd shift edge; mask=32'hFFFF_FFFF; sat=0; popcount unit returns 32.
- cnt=0 -> done one edge after accept, mask=0, busy never high.
- cnt=6'd40 -> sat=1, mask=32'hFFFF_FFFF after 32 shifts; next start with cnt=1 clears sat and gives mask=32'h1.
- cnt=3, then pulse start with cnt=9 during FILL -> ignored, final mask=32'h7. Then start cnt=9 in DONE -> mask=32'h1FF.
- Sweep cnt=0..32 back-to-back with start held high -> each result matches ((1<<n)-1) (LSB build) and done pulses once per result. Repeat with BITMASK_GEN_MSB_FILL_EN defined: cnt=1 gives 32'h8000_0000, cnt=2 gives 32'hC000_0000.
